instruction_fetch_stage: RTL

Instruction fetch (IF) stage of the pipelined processor: owns the program counter and the instruction memory, and produces the next sequential PC and fetched instruction that the IF/ID pipeline register captures. Instruction memory is filled byte-by-byte from the debug/loader unit before execution. A small state machine sequences load, run and halt phases.

---
 rtl/instruction_fetch_stage.sv | 130 +++++++++++++
 1 files changed

// File: rtl/instruction_fetch_stage.sv
// IF stage: PC register, byte-loaded big-endian instruction memory and LOAD/RUN/HALT sequencer.
// Optional macro IF_HALT_OPCODE_EN: halt on opcode 6'b111111 instead of running off the loaded image.
module instruction_fetch_stage #(
    parameter int unsigned PC_SIZE   = 32,
    parameter int unsigned WORD_SIZE = 32,
    parameter int unsigned MEM_WORDS = 64
) (
    input  logic                 i_clk,
    input  logic                 i_reset,
    input  logic                 i_enable,
    input  logic                 i_stall,
    input  logic                 i_branch_taken,
    input  logic [PC_SIZE-1:0]   i_branch_target,
    input  logic                 i_load_valid,
    input  logic [7:0]           i_load_byte,
    input  logic                 i_start,
    input  logic                 i_reload,
    output logic [PC_SIZE-1:0]   o_next_seq_pc,
    output logic [WORD_SIZE-1:0] o_instruction,
    output logic [PC_SIZE-1:0]   o_pc,
    output logic                 o_halt,
    output logic                 o_mem_full,
    output logic                 o_mem_empty,
    output logic [1:0]           o_state
);
    localparam int unsigned AW        = $clog2(MEM_WORDS);
    localparam int unsigned PTR_W     = AW + 3;
    localparam int unsigned MEM_BYTES = MEM_WORDS * 4;

    typedef enum logic [1:0] {
        S_LOAD = 2'b00,
        S_RUN  = 2'b01,
        S_HALT = 2'b10
    } state_t;

    state_t               state_q, state_d;
    logic [PC_SIZE-1:0]   pc_q, pc_d;
    logic [PTR_W-1:0]     ptr_q, ptr_d;
    logic [WORD_SIZE-1:0] mem_q [MEM_WORDS];
    logic [AW:0]          word_cnt;
    logic [PC_SIZE-1:0]   seq_pc;
    logic                 wr_en;
    logic                 fetch_ok;
    logic                 halt_cond;
    logic                 advance;

    assign word_cnt      = ptr_q[PTR_W-1:2];
    assign o_mem_full    = (ptr_q == PTR_W'(MEM_BYTES));
    assign o_mem_empty   = (word_cnt == '0);
    assign seq_pc        = pc_q + PC_SIZE'(4);
    assign advance       = i_enable && !i_stall;

    // Only whole words already written are fetchable; anything else reads as NOP.
    assign fetch_ok      = (pc_q < PC_SIZE'(MEM_BYTES)) && ({1'b0, pc_q[AW+1:2]} < word_cnt);
    assign o_instruction = fetch_ok ? mem_q[pc_q[AW+1:2]] : '0;

`ifdef IF_HALT_OPCODE_EN
    assign halt_cond = (o_instruction[WORD_SIZE-1 -: 6] == 6'b111111);
`else
    assign halt_cond = !((seq_pc < PC_SIZE'(MEM_BYTES)) && ({1'b0, seq_pc[AW+1:2]} < word_cnt));
`endif

    assign o_pc          = pc_q;
    assign o_next_seq_pc = seq_pc;
    assign o_halt        = (state_q == S_HALT);
    assign o_state       = state_q;

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state_q <= S_LOAD;
            pc_q    <= '0;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ptr_q   <= ptr_d;
        end
    end

    // Byte 0 of each word lands in the most significant lane.
    always_ff @(posedge i_clk) begin
        if (wr_en) begin
            case (ptr_q[1:0])
                2'd0:    mem_q[ptr_q[AW+1:2]][WORD_SIZE-1  -: 8] <= i_load_byte;
                2'd1:    mem_q[ptr_q[AW+1:2]][WORD_SIZE-9  -: 8] <= i_load_byte;
                2'd2:    mem_q[ptr_q[AW+1:2]][WORD_SIZE-17 -: 8] <= i_load_byte;
                default: mem_q[ptr_q[AW+1:2]][WORD_SIZE-25 -: 8] <= i_load_byte;
            endcase
        end
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        ptr_d   = ptr_q;
        wr_en   = 1'b0;
        unique case (state_q)
            S_LOAD: begin
                if (i_load_valid && !o_mem_full) begin
                    wr_en = 1'b1;
                    ptr_d = ptr_q + PTR_W'(1);
                end
                if (i_start && !o_mem_empty) begin
                    state_d = S_RUN;
                    pc_d    = '0;
                end
            end
            S_RUN: begin
                if (advance) begin
                    if (i_branch_taken) begin
                        pc_d = i_branch_target;
                    end else if (halt_cond) begin
                        state_d = S_HALT;
                    end else begin
                        pc_d = seq_pc;
                    end
                end
            end
            S_HALT: begin
                if (i_reload) begin
                    state_d = S_LOAD;
                    ptr_d   = '0;
                    pc_d    = '0;
                end
            end
            default: state_d = S_LOAD;
        endcase
    end

endmodule
